// File: rtl/fft_display_scheduler_pkg.sv
// Shared sizes and FSM encoding for the FFT display scheduler.
package fft_disp_pkg;
  localparam int FFT_BINS = 512;
  localparam int BIN_W    = 9;
  localparam int MAG_W    = 24;
  localparam int DROP_W   = 16;

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_READY   = 3'd3,
    ST_UPDATE  = 3'd4
  } state_e;
endpackage

// File: rtl/fft_display_scheduler_if.sv
// Scheduler bus: FFT magnitude input, visualizer write port and status flags.
interface fft_display_scheduler_if;
  import fft_disp_pkg::*;

  logic [BIN_W-1:0]  i_fft_addr;
  logic [MAG_W-1:0]  i_fft_mag;
  logic              i_fft_valid;
  logic [BIN_W-1:0]  o_vis_addr;
  logic [MAG_W-1:0]  o_vis_mag;
  logic              o_vis_valid;
  logic              o_busy;
  logic [DROP_W-1:0] o_drop_count;
  logic              o_seq_error;

  modport master (
    input  i_fft_addr, i_fft_mag, i_fft_valid,
    output o_vis_addr, o_vis_mag, o_vis_valid, o_busy, o_drop_count, o_seq_error
  );

  modport slave (
    output i_fft_addr, i_fft_mag, i_fft_valid,
    input  o_vis_addr, o_vis_mag, o_vis_valid, o_busy, o_drop_count, o_seq_error
  );
endinterface

// File: rtl/fft_display_scheduler_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module sdp_ram #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata <= mem_q[raddr];
  end
endmodule

// File: rtl/fft_display_scheduler.sv
// Captures one in-order FFT frame, then on a refresh tick runs a peak-hold/decay
// pass over all bins and streams the result to the visualizer RAM.
//   state      | meaning
//   ST_CLEAR   | zeroing hold RAM, one address per cycle
//   ST_IDLE    | waiting for bin 0 of a new frame
//   ST_CAPTURE | storing bins in order, expecting exp_q next
//   ST_READY   | full frame held, waiting for a pending refresh tick
//   ST_UPDATE  | decay/peak pass, 512 emits after a 2-cycle pipeline
module fft_display_scheduler
  import fft_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 833333,
  parameter int DECAY_SHIFT = 3
) (
  input  logic sys_clk,
  input  logic sys_reset,
  fft_display_scheduler_if.master bus
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int PTR_W = BIN_W + 1;

  state_e            state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [BIN_W-1:0]  exp_q;
  logic [CNT_W-1:0]  tick_cnt_q;
  logic              tick_pend_q;
  logic              rd_vld_q;
  logic [BIN_W-1:0]  rd_addr_q;
  logic              vis_valid_q;
  logic [BIN_W-1:0]  vis_addr_q;
  logic [MAG_W-1:0]  vis_mag_q;
  logic              busy_q;
  logic [DROP_W-1:0] drop_q;
  logic              seq_err_q;

  logic              tick;
  logic              fft_start;
  logic              cap_we;
  logic              hold_we;
  logic [BIN_W-1:0]  hold_waddr;
  logic [MAG_W-1:0]  hold_wdata;
  logic [MAG_W-1:0]  cap_rd;
  logic [MAG_W-1:0]  hold_rd;
  logic [MAG_W-1:0]  hold_dec;
  logic [MAG_W-1:0]  new_mag;

  assign tick      = (tick_cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign fft_start = bus.i_fft_valid && (bus.i_fft_addr == '0);
  assign cap_we    = bus.i_fft_valid &&
                     (((state_q == ST_IDLE) && (bus.i_fft_addr == '0)) ||
                      ((state_q == ST_CAPTURE) &&
                       ((bus.i_fft_addr == exp_q) || (bus.i_fft_addr == '0))));

  // Outside CLEAR the registered emit doubles as the hold write-back.
  assign hold_we    = (state_q == ST_CLEAR) || vis_valid_q;
  assign hold_waddr = (state_q == ST_CLEAR) ? ptr_q[BIN_W-1:0] : vis_addr_q;
  assign hold_wdata = (state_q == ST_CLEAR) ? '0 : vis_mag_q;

  sdp_ram #(.WIDTH(MAG_W), .DEPTH(FFT_BINS)) u_cap_ram (
    .clk   (sys_clk),
    .we    (cap_we),
    .waddr (bus.i_fft_addr),
    .wdata (bus.i_fft_mag),
    .raddr (ptr_q[BIN_W-1:0]),
    .rdata (cap_rd)
  );

  sdp_ram #(.WIDTH(MAG_W), .DEPTH(FFT_BINS)) u_hold_ram (
    .clk   (sys_clk),
    .we    (hold_we),
    .waddr (hold_waddr),
    .wdata (hold_wdata),
    .raddr (ptr_q[BIN_W-1:0]),
    .rdata (hold_rd)
  );

  always_comb begin
    hold_dec = '0;
    if (DECAY_SHIFT != 0) hold_dec = hold_rd - (hold_rd >> DECAY_SHIFT);
    new_mag = (cap_rd > hold_dec) ? cap_rd : hold_dec;
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      exp_q       <= '0;
      tick_cnt_q  <= '0;
      tick_pend_q <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
      vis_valid_q <= 1'b0;
      vis_addr_q  <= '0;
      vis_mag_q   <= '0;
      busy_q      <= 1'b1;
      drop_q      <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      tick_cnt_q  <= tick ? '0 : tick_cnt_q + 1'b1;
      if (tick) tick_pend_q <= 1'b1;
      rd_vld_q    <= 1'b0;
      vis_valid_q <= rd_vld_q;
      if (rd_vld_q) begin
        vis_addr_q <= rd_addr_q;
        vis_mag_q  <= new_mag;
      end
      if (fft_start && ((state_q == ST_READY) || (state_q == ST_UPDATE)) && (drop_q != '1))
        drop_q <= drop_q + 1'b1;

      case (state_q)
        ST_CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == PTR_W'(FFT_BINS - 1)) begin
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (fft_start) begin
            exp_q   <= BIN_W'(1);
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (bus.i_fft_valid) begin
            if (bus.i_fft_addr == exp_q) begin
              exp_q <= exp_q + 1'b1;
              if (bus.i_fft_addr == BIN_W'(FFT_BINS - 1)) state_q <= ST_READY;
            end else begin
              seq_err_q <= 1'b1;
              if (bus.i_fft_addr == '0) exp_q <= BIN_W'(1);
              else state_q <= ST_IDLE;
            end
          end
        end
        ST_READY: begin
          // Consuming wins over a coincident tick.
          if (tick_pend_q) begin
            tick_pend_q <= 1'b0;
            ptr_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          if (!ptr_q[BIN_W]) begin
            rd_vld_q  <= 1'b1;
            rd_addr_q <= ptr_q[BIN_W-1:0];
            ptr_q     <= ptr_q + 1'b1;
          end
          if (vis_valid_q && (vis_addr_q == BIN_W'(FFT_BINS - 1))) begin
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b1;
          ptr_q   <= '0;
          state_q <= ST_CLEAR;
        end
      endcase
    end
  end

  assign bus.o_vis_addr   = vis_addr_q;
  assign bus.o_vis_mag    = vis_mag_q;
  assign bus.o_vis_valid  = vis_valid_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_drop_count = drop_q;
  assign bus.o_seq_error  = seq_err_q;
endmodule

// File: tb/tb_fft_display_scheduler.sv
// Self-checking bench: randomized frames against a frame-level reference model.
module tb_fft_display_scheduler;
  localparam int DIV   = 1024;
  localparam int SHIFT = 3;

  typedef enum int {M_CLEAR, M_IDLE, M_CAPTURE, M_READY, M_UPDATE} mode_t;

  logic clk;
  logic rst;
  fft_display_scheduler_if bus ();

  fft_display_scheduler #(.REFRESH_DIV(DIV), .DECAY_SHIFT(SHIFT)) dut (
    .sys_clk   (clk),
    .sys_reset (rst),
    .bus       (bus.master)
  );

  int checks = 0;
  int errors = 0;

  mode_t       m_mode;
  int          m_clr, m_cnt, m_exp, m_n, m_drop, passes;
  bit          m_pend, m_seq;
  int unsigned cap_m [512];
  int unsigned hold_m [512];
  int unsigned exp_mag [512];

  logic [23:0] frame_mag [512];
  logic [23:0] got_mag [512];
  int          dut_emits;
  logic [23:0] decay_lit [4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // Reference model: advances once per clock edge from the spec's rules.
  task automatic model_step();
    bit          tick;
    bit          consumed;
    bit          v;
    int          a;
    int unsigned dec;
    if (rst) begin
      m_mode = M_CLEAR; m_clr = 0; m_cnt = 0; m_exp = 0; m_n = 0;
      m_drop = 0; m_pend = 0; m_seq = 0;
      foreach (hold_m[i]) hold_m[i] = 0;
      return;
    end
    v = (bus.i_fft_valid === 1'b1);
    a = int'(bus.i_fft_addr);
    tick = (m_cnt == DIV - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    consumed = 0;
    if (v && a == 0 && (m_mode == M_READY || m_mode == M_UPDATE) && m_drop < 65535) m_drop++;
    case (m_mode)
      M_CLEAR: begin
        m_clr++;
        if (m_clr == 512) m_mode = M_IDLE;
      end
      M_IDLE: if (v && a == 0) begin
        cap_m[0] = bus.i_fft_mag; m_exp = 1; m_mode = M_CAPTURE;
      end
      M_CAPTURE: if (v) begin
        if (a == m_exp) begin
          cap_m[a] = bus.i_fft_mag; m_exp++;
          if (a == 511) m_mode = M_READY;
        end else begin
          m_seq = 1;
          if (a == 0) begin cap_m[0] = bus.i_fft_mag; m_exp = 1; end
          else m_mode = M_IDLE;
        end
      end
      M_READY: if (m_pend) begin
        consumed = 1;
        for (int i = 0; i < 512; i++) begin
          dec = (SHIFT == 0) ? 0 : hold_m[i] - (hold_m[i] >> SHIFT);
          exp_mag[i] = (cap_m[i] > dec) ? cap_m[i] : dec;
          hold_m[i] = exp_mag[i];
        end
        m_mode = M_UPDATE; m_n = 0;
      end
      M_UPDATE: begin
        m_n++;
        if (m_n == 514) begin m_mode = M_IDLE; passes++; end
      end
      default: m_mode = M_CLEAR;
    endcase
    if (consumed) m_pend = 0;
    else if (tick) m_pend = 1;
  endtask

  initial begin
    passes = 0;
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    bit exp_v;
    forever begin
      @(negedge clk);
      exp_v = (m_mode == M_UPDATE && m_n >= 2 && m_n <= 513);
      chk("vis_valid", {31'd0, bus.o_vis_valid}, {31'd0, exp_v});
      if (exp_v) begin
        chk("vis_addr", {23'd0, bus.o_vis_addr}, m_n - 2);
        chk("vis_mag", {8'd0, bus.o_vis_mag}, exp_mag[m_n - 2]);
      end
      chk("busy", {31'd0, bus.o_busy}, {31'd0, (m_mode == M_CLEAR || m_mode == M_UPDATE)});
      chk("drop_count", {16'd0, bus.o_drop_count}, m_drop);
      chk("seq_error", {31'd0, bus.o_seq_error}, {31'd0, m_seq});
      if (bus.o_vis_valid === 1'b1) begin
        got_mag[bus.o_vis_addr] = bus.o_vis_mag;
        dut_emits++;
      end
    end
  end

  task automatic drive(input bit v, input int a, input logic [23:0] mag);
    bus.i_fft_valid = v;
    bus.i_fft_addr  = 9'(a);
    bus.i_fft_mag   = mag;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int gap_max);
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, i, frame_mag[i]);
      if (gap_max > 0) repeat ($urandom_range(gap_max)) drive(1'b0, $urandom_range(511), 24'($urandom));
    end
    drive(1'b0, 0, 24'd0);
  endtask

  task automatic clear_got();
    foreach (got_mag[i]) got_mag[i] = 24'hFFFFFF;
    dut_emits = 0;
  endtask

  task automatic wait_pass(input string name);
    int start;
    int c;
    start = passes;
    c = 0;
    while (passes == start && c < 4000) begin
      @(posedge clk); #1; c++;
    end
    if (passes == start) timeout(name);
  endtask

  task automatic wait_mode(input mode_t m, input int budget, input string name);
    int c;
    c = 0;
    while (m_mode != m && c < budget) begin
      @(posedge clk); #1; c++;
    end
    if (m_mode != m) timeout(name);
  endtask

  task automatic count_bad(output int bad);
    bad = 0;
    for (int i = 0; i < 512; i++) if (got_mag[i] !== frame_mag[i]) bad++;
  endtask

  initial begin
    int bad;
    int c;
    decay_lit[0] = 24'h000800; decay_lit[1] = 24'h000700;
    decay_lit[2] = 24'h000620; decay_lit[3] = 24'h00055C;
    bus.i_fft_valid = 1'b0; bus.i_fft_addr = '0; bus.i_fft_mag = '0;
    rst = 1'b0;
    dut_emits = 0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vis_addr", {23'd0, bus.o_vis_addr}, 0);
    chk("rst_vis_mag", {8'd0, bus.o_vis_mag}, 0);
    chk("rst_vis_valid", {31'd0, bus.o_vis_valid}, 0);
    chk("rst_busy", {31'd0, bus.o_busy}, 1);
    chk("rst_drop", {16'd0, bus.o_drop_count}, 0);
    chk("rst_seq", {31'd0, bus.o_seq_error}, 0);
    rst = 1'b0;

    // Junk traffic during CLEAR must be ignored and not counted.
    for (int i = 0; i < 20; i++) drive(1'b1, (i % 2 == 0) ? 0 : $urandom_range(511), 24'($urandom));
    drive(1'b0, 0, 24'd0);
    wait_mode(M_IDLE, 700, "clear_done");
    chk("clear_busy_low", {31'd0, bus.o_busy}, 0);
    chk("clear_no_drop", {16'd0, bus.o_drop_count}, 0);

    // Decay: one 0x800 frame, then three zero frames.
    for (int p = 0; p < 4; p++) begin
      foreach (frame_mag[i]) frame_mag[i] = (p == 0) ? 24'h000800 : 24'h0;
      clear_got();
      send_frame(0);
      wait_pass("decay_pass");
      chk("decay_emits", dut_emits, 512);
      chk("decay_bin0", {8'd0, got_mag[0]}, {8'd0, decay_lit[p]});
      chk("decay_bin511", {8'd0, got_mag[511]}, {8'd0, decay_lit[p]});
    end

    // Drops: a frame start while READY and again during UPDATE.
    foreach (frame_mag[i]) frame_mag[i] = 24'h100000 | 24'($urandom_range(24'hFFFFF));
    clear_got();
    send_frame(0);
    drive(1'b1, 0, 24'($urandom));
    drive(1'b1, 1, 24'($urandom));
    drive(1'b0, 0, 24'd0);
    wait_mode(M_UPDATE, 2000, "drop_wait_update");
    drive(1'b1, 0, 24'($urandom));
    drive(1'b0, 0, 24'd0);
    wait_pass("drop_pass");
    chk("drop_count_two", {16'd0, bus.o_drop_count}, 2);
    chk("drop_emits", dut_emits, 512);
    count_bad(bad);
    chk("drop_frame_intact", bad, 0);

    // Sequence error: 0,1,2,5 -> back to IDLE, no pass at the next tick.
    drive(1'b1, 0, 24'h1); drive(1'b1, 1, 24'h2); drive(1'b1, 2, 24'h3); drive(1'b1, 5, 24'h4);
    drive(1'b0, 0, 24'd0);
    chk("seq_error_set", {31'd0, bus.o_seq_error}, 1);
    dut_emits = 0;
    repeat (2 * DIV + 100) @(posedge clk);
    #1;
    chk("seq_no_update", dut_emits, 0);
    chk("seq_busy_low", {31'd0, bus.o_busy}, 0);

    // Randomized frames, the first preceded by an aborted partial frame.
    for (int f = 0; f < 3; f++) begin
      if (f == 0) for (int i = 0; i < 100; i++) drive(1'b1, i, 24'($urandom));
      foreach (frame_mag[i]) frame_mag[i] = 24'($urandom);
      clear_got();
      send_frame(3);
      wait_pass("rand_pass");
      chk("rand_emits", dut_emits, 512);
    end

    // Async reset at the 100th emit of a pass.
    foreach (frame_mag[i]) frame_mag[i] = 24'h800000 | 24'($urandom_range(24'h7FFFFF));
    send_frame(0);
    c = 0;
    while (!(m_mode == M_UPDATE && m_n == 101) && c < 4000) begin
      @(posedge clk); #1; c++;
    end
    if (!(m_mode == M_UPDATE && m_n == 101)) timeout("wait_emit100");
    chk("pre_rst_addr", {23'd0, bus.o_vis_addr}, 99);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, bus.o_vis_valid}, 0);
    chk("mid_rst_busy", {31'd0, bus.o_busy}, 1);
    chk("mid_rst_drop", {16'd0, bus.o_drop_count}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_mode(M_IDLE, 700, "reclear_done");

    // Single ramp frame on a freshly cleared hold RAM.
    for (int i = 0; i < 512; i++) frame_mag[i] = 24'(i * 16);
    clear_got();
    send_frame(0);
    wait_pass("ramp_pass");
    chk("ramp_emits", dut_emits, 512);
    chk("ramp_bin1", {8'd0, got_mag[1]}, 16);
    chk("ramp_bin511", {8'd0, got_mag[511]}, 32'h1FF0);
    count_bad(bad);
    chk("ramp_all_bins", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_display_scheduler.md
# fft_display_scheduler

Controller between the FFT magnitude stream and the visualizer's RAM write port (sys_clk side). Captures one complete, in-order 512-bin FFT frame, then at a programmable refresh rate runs a peak-hold/decay pass over all bins and streams the results into the visualizer as an address/magnitude/valid burst. It decouples the bursty FFT output rate from the display update rate and drops frames that arrive while a frame is held or being pushed.

## Interface
Parameters:
- REFRESH_DIV, 833333: sys_clk cycles between refresh ticks (60 Hz at 50 MHz); legal range ≥ 1024.
- DECAY_SHIFT, 3: decay per pass is hold >> DECAY_SHIFT; 0 means the hold is fully cleared each pass.

Ports (one clock; reset is asynchronous and active-high):
- sys_clk  in  1  system clock.
- sys_reset  in  1  asynchronous active-high reset.
- i_fft_addr  in  9  bin index of the current FFT sample.
- i_fft_mag  in  24  unsigned bin magnitude.
- i_fft_valid  in  1  sample strobe, one bin per asserted cycle.
- o_vis_addr  out  9  bin index to the visualizer write port.
- o_vis_mag  out  24  smoothed magnitude to the visualizer.
- o_vis_valid  out  1  visualizer write strobe.
- o_busy  out  1  high in CLEAR and UPDATE.
- o_drop_count  out  16  saturating count of dropped frames.
- o_seq_error  out  1  sticky flag: out-of-order bin seen during capture.

## Operation
- States: CLEAR, IDLE, CAPTURE, READY, UPDATE.
- CLEAR, entered on reset: writes 0 to hold RAM addresses 0..511, one per cycle (512 cycles), then IDLE. Valid samples are ignored; frame starts are not counted.
- IDLE: valid with addr==0 writes capture[0]; expected address becomes 1; state goes to CAPTURE. Valid with addr≠0 is ignored.
- CAPTURE: valid with addr==expected writes capture[addr] and increments expected. At addr==511 the state goes to READY. Valid with addr≠expected sets o_seq_error and returns to IDLE. If that sample has addr==0, it restarts capture in the same cycle.
- READY: waits for tick_pending, then enters UPDATE and clears tick_pending.
- UPDATE: for i = 0..511, read capture[i] and hold[i]. Compute dec = hold − (hold >> DECAY_SHIFT), or 0 if DECAY_SHIFT==0. Compute new = max(cap, dec). Write hold[i] = new and emit (i, new) with o_vis_valid. After the 512th emit, go to IDLE.
- Drops: valid with addr==0 while in READY or UPDATE increments o_drop_count, saturating at 0xFFFF. In CAPTURE, addr==0 is treated as a sequence error (above), not a drop.
- Tick: a free-running counter runs 0..REFRESH_DIV−1 and pulses tick at wrap. tick sets tick_pending, which is held until consumed. Multiple ticks merge into one. The counter runs in every state except reset.
- Simultaneous tick and consume: pending stays cleared; the new tick is lost only if it coincides with the consume cycle. That case is allowed.
- Arithmetic: all values are 24-bit unsigned. No overflow is possible; dec ≤ hold.
- Reset values: o_vis_addr=0, o_vis_mag=0, o_vis_valid=0, o_busy=1 (entering CLEAR), o_drop_count=0, o_seq_error=0, counter=0, tick_pending=0.
- Reset asserted mid-UPDATE or mid-CAPTURE: outputs go to reset values immediately, and the block re-runs CLEAR.

## Timing
- RAMs are synchronous read with 1-cycle latency. The UPDATE pipeline is issue addr, then RAM data, then registered compute/output.
- The first o_vis_valid occurs 2 cycles after UPDATE entry. 512 consecutive valid cycles follow, addresses 0..511 ascending, with no gaps.
- Hold write-back happens in the same cycle as the emit. There is no read/write hazard, since each address is read once per pass.
- UPDATE lasts 514 cycles. o_busy falls in the cycle after the last emit.
- Capture write happens on the valid cycle. READY is entered the cycle after the addr==511 sample.
- FFT input has no backpressure. The block never stalls the source.

## Structure
- Package fft_disp_pkg holds:
  - FFT_BINS=512, BIN_W=9, MAG_W=24;
  - state enum encoding;
  - DROP_W=16.
- Sub-module sdp_ram (parameters WIDTH, DEPTH; one write port, one registered read port, single clock), instantiated twice: capture buffer and hold buffer.
- Top level holds the FSM, expected-address counter, update pointer, tick counter and compute stage.

## Test plan
- Reset: after release, o_busy is high for 512 cycles, then IDLE. All outputs are 0, and no o_vis_valid occurs during CLEAR.
- Single frame: stream bins 0..511 with mag = addr×16, then force a tick. Expect 512 writes with o_vis_mag[i] = i×16, first valid 2 cycles after UPDATE entry.
- Decay: frame of all 0x000800, then three frames of all 0 with DECAY_SHIFT=3. Expect outputs 0x800, then 0x700, 0x620, 0x55C.
- Drop: start a second frame (addr 0) while READY and again during UPDATE. Expect o_drop_count=2 and the first frame's data emitted unchanged.
- Sequence error: send bins 0,1,2,5. Expect o_seq_error=1, state IDLE, and no UPDATE at the next tick.
- Async reset mid-UPDATE, asserted at the 100th emit: expect o_vis_valid=0 immediately, o_busy=1, CLEAR re-run, and hold RAM reading zero on the next pass.
